// File: rtl/lsu_mmio_hs_pkg.sv
// Shared types, IO address map and byte-lane helpers for the MMIO load/store unit.
package lsu_pkg;

  // Stores reuse the load encodings: SB=LB, SH=LH, SW=LW.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3_e;

  localparam funct3_e SB = LB;
  localparam funct3_e SH = LH;
  localparam funct3_e SW = LW;

  typedef enum logic {IDLE, ACCESS} lsu_state_e;

  typedef enum logic [3:0] {
    IO_NONE, IO_LEDR, IO_LEDG, IO_HEX0, IO_HEX1, IO_LCD, IO_SW, IO_BTN, IO_EVT
  } io_sel_e;

  localparam logic [15:0] ADDR_LEDR    = 16'h7000;
  localparam logic [15:0] ADDR_LEDG    = 16'h7010;
  localparam logic [15:0] ADDR_HEX0    = 16'h7020;
  localparam logic [15:0] ADDR_HEX1    = 16'h7024;
  localparam logic [15:0] ADDR_LCD     = 16'h7030;
  localparam logic [15:0] ADDR_SW      = 16'h7800;
  localparam logic [15:0] ADDR_BTN     = 16'h7810;
  localparam logic [15:0] ADDR_BTN_EVT = 16'h7814;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    return 4'b0001 << lane;
      2'd1:    return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] apply_be(input logic [31:0] cur, input logic [31:0] nxt,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = nxt[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/lsu_mmio_hs_if.sv
// Request/response handshake between the core's memory stage and the load/store unit.
interface lsu_mmio_hs_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wren;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] st_data;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] ld_data;

  modport master (
    output req_valid, req_wren, req_addr, req_funct3, st_data,
    input  req_ready, rsp_valid, rsp_err, ld_data
  );

  modport slave (
    input  req_valid, req_wren, req_addr, req_funct3, st_data,
    output req_ready, rsp_valid, rsp_err, ld_data
  );
endinterface

// File: rtl/lsu_mmio_hs_dmem.sv
// Byte-enabled single-port data memory with a registered read port; contents are not reset.
module lsu_dmem #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lsu_mmio_hs.sv
// Load/store unit: valid/ready request FSM, RV32 sized access to DMEM and board IO,
// input synchronisers and a read-to-clear button event register.
module lsu_mmio_hs
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH = 2048,
  parameter logic [31:0] DMEM_BASE  = 32'h2000,
  parameter int unsigned NUM_HEX    = 8,
  parameter int unsigned NUM_BTN    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  lsu_mmio_hs_if.slave         bus,
  input  logic [31:0]          i_io_sw,
  input  logic [NUM_BTN-1:0]   i_io_btn,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd
);

  localparam int unsigned AW        = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [31:0] DMEM_SPAN = 32'(DMEM_DEPTH) * 32'd4;

  lsu_state_e state_q, state_d;
  logic       accept;

  // Request decode
  logic [1:0]    size;
  logic [1:0]    lane;
  logic          f3_ok, misaligned, dmem_hit, err_now;
  logic [15:0]   io_word;
  io_sel_e       io_sel;
  logic [3:0]    be;
  logic [31:0]   be_bits, wdata, io_rd;
  logic [AW-1:0] dmem_idx;
  logic          dmem_en, io_we;
  logic [31:0]   dmem_q;

  // IO state
  logic [31:0]              sw_s1, sw_s2;
  logic [NUM_BTN-1:0]       btn_s1, btn_s2, btn_d, btn_evt, evt_clr;
  logic [31:0]              ledr, ledg, lcd;
  logic [7:0][6:0]          hex_q;

  // Captured response context
  logic        r_wren, r_err, r_dmem;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [31:0] r_io;
  logic [31:0] rsp_word, shifted, ld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    size       = bus.req_funct3[1:0];
    lane       = bus.req_addr[1:0];
    f3_ok      = bus.req_wren ? (bus.req_funct3 inside {LB, LH, LW})
                              : (bus.req_funct3 inside {LB, LH, LW, LBU, LHU});
    misaligned = ((size == 2'd1) && bus.req_addr[0]) ||
                 ((size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
    dmem_hit   = (bus.req_addr >= DMEM_BASE) && ((bus.req_addr - DMEM_BASE) < DMEM_SPAN);
    dmem_idx   = AW'((bus.req_addr - DMEM_BASE) >> 2);
    io_word    = {bus.req_addr[15:2], 2'b00};
    io_sel     = IO_NONE;
    if (!dmem_hit) begin
      case (io_word)
        ADDR_LEDR:    io_sel = IO_LEDR;
        ADDR_LEDG:    io_sel = IO_LEDG;
        ADDR_HEX0:    io_sel = IO_HEX0;
        ADDR_HEX1:    io_sel = IO_HEX1;
        ADDR_LCD:     io_sel = IO_LCD;
        ADDR_SW:      io_sel = IO_SW;
        ADDR_BTN:     io_sel = IO_BTN;
        ADDR_BTN_EVT: io_sel = IO_EVT;
        default:      io_sel = IO_NONE;
      endcase
    end
    err_now = !f3_ok || misaligned || (!dmem_hit && (io_sel == IO_NONE));
    be      = lane_mask(size, lane);
    be_bits = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    case (size)
      2'd0:    wdata = {4{bus.st_data[7:0]}};
      2'd1:    wdata = {2{bus.st_data[15:0]}};
      default: wdata = bus.st_data;
    endcase
    dmem_en = accept && dmem_hit && !err_now;
    io_we   = accept && bus.req_wren && !err_now && !dmem_hit;
    // Only the event bits inside the lanes actually returned get cleared.
    evt_clr = (accept && !bus.req_wren && !err_now && (io_sel == IO_EVT))
              ? (btn_evt & NUM_BTN'(be_bits)) : '0;
    case (io_sel)
      IO_LEDR: io_rd = ledr;
      IO_LEDG: io_rd = ledg;
      IO_HEX0: io_rd = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
      IO_HEX1: io_rd = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
      IO_LCD:  io_rd = lcd;
      IO_SW:   io_rd = sw_s2;
      IO_BTN:  io_rd = 32'(btn_s2);
      IO_EVT:  io_rd = 32'(btn_evt);
      default: io_rd = '0;
    endcase
  end

  lsu_dmem #(.DEPTH(DMEM_DEPTH), .AW(AW)) u_dmem (
    .clk   (i_clk),
    .en    (dmem_en),
    .we    (bus.req_wren ? be : 4'b0000),
    .addr  (dmem_idx),
    .wdata (wdata),
    .rdata (dmem_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_d   <= '0;
      btn_evt <= '0;
      ledr    <= '0;
      ledg    <= '0;
      lcd     <= '0;
      hex_q   <= '0;
      r_wren  <= 1'b0;
      r_err   <= 1'b0;
      r_dmem  <= 1'b0;
      r_f3    <= '0;
      r_lane  <= '0;
      r_io    <= '0;
    end else begin
      sw_s1   <= i_io_sw;
      sw_s2   <= sw_s1;
      btn_s1  <= i_io_btn;
      btn_s2  <= btn_s1;
      btn_d   <= btn_s2;
      // A rising edge on the clearing cycle survives the clear.
      btn_evt <= (btn_evt & ~evt_clr) | (btn_s2 & ~btn_d);
      if (io_we) begin
        case (io_sel)
          IO_LEDR: ledr <= apply_be(ledr, wdata, be);
          IO_LEDG: ledg <= apply_be(ledg, wdata, be);
          IO_LCD:  lcd  <= apply_be(lcd, wdata, be);
          IO_HEX0, IO_HEX1: begin
            for (int unsigned k = 0; k < 8; k++)
              if ((k < NUM_HEX) && ((k / 4) == ((io_sel == IO_HEX1) ? 1 : 0)) && be[k % 4])
                hex_q[k] <= wdata[8*(k % 4) +: 7];
          end
          default: ;
        endcase
      end
      if (accept) begin
        r_wren <= bus.req_wren;
        r_err  <= err_now;
        r_dmem <= dmem_hit;
        r_f3   <= bus.req_funct3;
        r_lane <= lane;
        r_io   <= io_rd;
      end
    end
  end

  always_comb begin
    rsp_word = r_dmem ? dmem_q : r_io;
    shifted  = rsp_word >> {r_lane, 3'b000};
    ld       = '0;
    if ((state_q == ACCESS) && !r_wren && !r_err) begin
      case (r_f3)
        LB:      ld = {{24{shifted[7]}}, shifted[7:0]};
        LH:      ld = {{16{shifted[15]}}, shifted[15:0]};
        LW:      ld = shifted;
        LBU:     ld = {24'd0, shifted[7:0]};
        LHU:     ld = {16'd0, shifted[15:0]};
        default: ld = '0;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == ACCESS);
  assign bus.rsp_err   = (state_q == ACCESS) && r_err;
  assign bus.ld_data   = ld;

  assign o_io_ledr = ledr;
  assign o_io_ledg = ledg;
  assign o_io_lcd  = lcd;
  assign o_io_hex  = hex_q[NUM_HEX-1:0];

endmodule

// File: tb/tb_lsu_mmio_hs.sv
// Directed and randomized bench for lsu_mmio_hs against a byte-level memory/IO model.
module tb_lsu_mmio_hs;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sw = '0;
  logic [3:0]  btn = '0;
  logic [31:0] ledr, ledg, lcd;
  logic [55:0] hex;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mmio_hs_if bus();

  lsu_mmio_hs #(.DMEM_DEPTH(2048), .DMEM_BASE(32'h2000), .NUM_HEX(8), .NUM_BTN(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .i_io_sw(sw), .i_io_btn(btn),
    .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd)
  );

  // Reference model: byte-addressed DMEM plus IO registers
  logic [7:0]  m_dmem [int unsigned];
  logic [31:0] m_ledr = '0, m_ledg = '0, m_lcd = '0, m_sw = '0;
  logic [6:0]  m_hex [8] = '{default: '0};
  logic [3:0]  m_btn = '0, m_evt = '0;

  function automatic bit io_mapped(input logic [15:0] lo);
    logic [15:0] w;
    w = lo & 16'hFFFC;
    return w inside {16'h7000, 16'h7010, 16'h7020, 16'h7024, 16'h7030,
                     16'h7800, 16'h7810, 16'h7814};
  endfunction

  task automatic get_byte(input logic [31:0] a, input bit in_dmem, output logic [7:0] v);
    logic [15:0] lo;
    int unsigned b;
    logic [31:0] word;
    lo = a[15:0];
    b  = lo[1:0];
    v  = '0;
    if (in_dmem) begin
      v = m_dmem.exists(a) ? m_dmem[a] : 8'hxx;
      return;
    end
    word = '0;
    case (lo & 16'hFFFC)
      16'h7000: word = m_ledr;
      16'h7010: word = m_ledg;
      16'h7030: word = m_lcd;
      16'h7800: word = m_sw;
      16'h7810: word = {28'd0, m_btn};
      16'h7814: begin
        word = {28'd0, m_evt};
        if (b == 0) m_evt = '0;
      end
      default: ;
    endcase
    if (lo >= 16'h7020 && lo < 16'h7028) v = {1'b0, m_hex[lo - 16'h7020]};
    else v = word[8*b +: 8];
  endtask

  task automatic put_byte(input logic [31:0] a, input bit in_dmem, input logic [7:0] v);
    logic [15:0] lo;
    int unsigned b;
    lo = a[15:0];
    b  = lo[1:0];
    if (in_dmem) begin
      m_dmem[a] = v;
      return;
    end
    case (lo & 16'hFFFC)
      16'h7000: m_ledr[8*b +: 8] = v;
      16'h7010: m_ledg[8*b +: 8] = v;
      16'h7030: m_lcd[8*b +: 8]  = v;
      16'h7020, 16'h7024: m_hex[lo - 16'h7020] = v[6:0];
      default: ;
    endcase
  endtask

  task automatic model_access(input bit w, input logic [31:0] a, input logic [2:0] f,
                              input logic [31:0] d, output bit err, output logic [31:0] ld);
    int unsigned n;
    logic [31:0] raw;
    logic [7:0]  v;
    bit          in_dmem;
    err = 1'b0;
    ld  = '0;
    raw = '0;
    n = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    in_dmem = (a >= 32'h2000) && (a < 32'h4000);
    if (w ? (f > 3'd2) : !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) err = 1'b1;
    else if ((a % n) != 0) err = 1'b1;
    else if (!in_dmem && !io_mapped(a[15:0])) err = 1'b1;
    if (err) return;
    for (int unsigned i = 0; i < n; i++) begin
      if (w) put_byte(a + i, in_dmem, d[8*i +: 8]);
      else begin
        get_byte(a + i, in_dmem, v);
        raw[8*i +: 8] = v;
      end
    end
    if (!w) begin
      case (f)
        3'd0: ld = {{24{raw[7]}}, raw[7:0]};
        3'd1: ld = {{16{raw[15]}}, raw[15:0]};
        3'd2: ld = raw;
        3'd4: ld = {24'd0, raw[7:0]};
        3'd5: ld = {16'd0, raw[15:0]};
        default: ld = '0;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_io(input string tag);
    logic [55:0] eh;
    for (int k = 0; k < 8; k++) eh[7*k +: 7] = m_hex[k];
    chk({tag, ".ledr"}, ledr, m_ledr);
    chk({tag, ".ledg"}, ledg, m_ledg);
    chk({tag, ".lcd"}, lcd, m_lcd);
    chk({tag, ".hex_lo"}, eh[31:0], hex[31:0]);
    chk({tag, ".hex_hi"}, 32'(eh[55:32]), 32'(hex[55:32]));
  endtask

  // Called just after a rising edge; returns just after the edge that ends the response.
  task automatic req(input string tag, input bit w, input logic [31:0] a,
                     input logic [2:0] f, input logic [31:0] d);
    bit          e;
    logic [31:0] ld;
    bus.req_valid = 1'b1;
    bus.req_wren = w;
    bus.req_addr = a;
    bus.req_funct3 = f;
    bus.st_data = d;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    model_access(w, a, f, d, e, ld);
    @(negedge clk);
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, ".busy"}, 32'(bus.req_ready), 32'd0);
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'(e));
    chk({tag, ".ld"}, bus.ld_data, ld);
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d, exp_a, exp_b;
    logic [15:0] io_list [8];
    bit          e;
    io_list = '{16'h7000, 16'h7010, 16'h7020, 16'h7024, 16'h7030, 16'h7800, 16'h7810, 16'h7814};

    bus.req_valid = 1'b0;
    bus.req_wren = 1'b0;
    bus.req_addr = '0;
    bus.req_funct3 = '0;
    bus.st_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", 32'(bus.req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.err", 32'(bus.rsp_err), 32'd0);
    chk("rst.ld", bus.ld_data, 32'd0);
    chk_io("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sw = $urandom;
    m_sw = sw;
    tick(3);

    // Sized loads with sign/zero extension
    req("t1.sw", 1, 32'h2000, 3'b010, 32'h80FF7F01);
    req("t1.lb0", 0, 32'h2000, 3'b000, 0);
    req("t1.lb3", 0, 32'h2003, 3'b000, 0);
    req("t1.lhu2", 0, 32'h2002, 3'b101, 0);
    req("t1.lh2", 0, 32'h2002, 3'b001, 0);

    // Byte/half store lanes
    req("t2.sw", 1, 32'h2000, 3'b010, 32'h11223344);
    req("t2.sb1", 1, 32'h2001, 3'b000, 32'h000000AB);
    req("t2.lw_a", 0, 32'h2000, 3'b010, 0);
    req("t2.sh2", 1, 32'h2002, 3'b001, 32'h0000BEEF);
    req("t2.lw_b", 0, 32'h2000, 3'b010, 0);

    // Errors: misaligned, bad funct3, unmapped
    req("t3.lw_mis", 0, 32'h2002, 3'b010, 0);
    req("t3.sh_mis", 1, 32'h2001, 3'b001, 32'h5555);
    req("t3.bad_f3", 0, 32'h2000, 3'b011, 0);
    req("t3.sbad_f3", 1, 32'h2000, 3'b100, 32'h77);
    req("t3.lw_keep", 0, 32'h2000, 3'b010, 0);
    req("t3.unmapped", 0, 32'h9000, 3'b010, 0);
    req("t3.dmem_top", 1, 32'h3FFC, 3'b010, 32'hCAFEF00D);
    req("t3.dmem_past", 0, 32'h4000, 3'b010, 0);
    req("t3.dmem_below", 0, 32'h1FFC, 3'b010, 0);

    // HEX / LED / LCD registers
    req("t4.hex_sw", 1, 32'h7020, 3'b010, 32'h0F0F0F0F);
    req("t4.hex_sb5", 1, 32'h7025, 3'b000, 32'h0000007F);
    chk_io("t4a");
    req("t4.ledr", 1, 32'h7000, 3'b010, $urandom);
    req("t4.ledg", 1, 32'h7010, 3'b010, $urandom);
    req("t4.lcd", 1, 32'h7030, 3'b010, $urandom);
    req("t4.ledr_rd", 0, 32'h7000, 3'b010, 0);
    req("t4.ledg_rd", 0, 32'h7010, 3'b010, 0);
    req("t4.lcd_rd", 0, 32'h7030, 3'b010, 0);
    req("t4.hex1_rd", 0, 32'h7024, 3'b010, 0);
    req("t4.ro_store", 1, 32'h7800, 3'b010, 32'hFFFFFFFF);
    chk_io("t4b");

    // Buttons, events, switches
    btn = 4'b1010;
    m_evt |= btn & ~m_btn;
    m_btn = btn;
    tick(3);
    req("t5.evt_a", 0, 32'h7814, 3'b010, 0);
    req("t5.evt_b", 0, 32'h7814, 3'b010, 0);
    req("t5.btn", 0, 32'h7810, 3'b010, 0);
    sw = 32'h12345678;
    m_sw = sw;
    tick(2);
    req("t5.sw", 0, 32'h7800, 3'b010, 0);
    // Synced edge lands on the accepting edge of the event read: not returned, stays set
    btn = 4'b1011;
    tick(2);
    req("t5.evt_race", 0, 32'h7814, 3'b010, 0);
    m_evt |= 4'b0001;
    m_btn = btn;
    req("t5.evt_kept", 0, 32'h7814, 3'b010, 0);
    req("t5.evt_clr", 0, 32'h7814, 3'b010, 0);

    // Prefill a DMEM window, then random traffic
    for (int i = 0; i < 16; i++) req("pre", 1, 32'h2000 + 4 * i, 3'b010, $urandom);
    for (int i = 0; i < 4; i++) req("pre_top", 1, 32'h3FF0 + 4 * i, 3'b010, $urandom);
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 5))
        0, 1: a = 32'h2000 + $urandom_range(0, 63);
        2:    a = 32'h3FF0 + $urandom_range(0, 15);
        3, 4: a = {16'd0, io_list[$urandom_range(0, 7)]} + $urandom_range(0, 3);
        default: a = ($urandom_range(0, 1) != 0) ? 32'h1FFC + $urandom_range(0, 3)
                                                   : 32'h4000 + $urandom_range(0, 255);
      endcase
      req("rnd", $urandom_range(0, 1) != 0, a, 3'($urandom_range(0, 7)), $urandom);
    end
    chk_io("rnd");

    // Back-to-back requests: ready toggles 1,0,1 and each response follows its accept
    bus.req_valid = 1'b1;
    bus.req_wren = 1'b0;
    bus.req_addr = 32'h2000;
    bus.req_funct3 = 3'b010;
    @(negedge clk);
    chk("b2b.ready0", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    model_access(0, 32'h2000, 3'b010, 0, e, exp_a);
    bus.req_addr = 32'h2004;
    @(negedge clk);
    chk("b2b.ready1", 32'(bus.req_ready), 32'd0);
    chk("b2b.rsp_a", 32'(bus.rsp_valid), 32'd1);
    chk("b2b.ld_a", bus.ld_data, exp_a);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("b2b.ready2", 32'(bus.req_ready), 32'd1);
    chk("b2b.rsp_gap", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    model_access(0, 32'h2004, 3'b010, 0, e, exp_b);
    @(negedge clk);
    chk("b2b.rsp_b", 32'(bus.rsp_valid), 32'd1);
    chk("b2b.ld_b", bus.ld_data, exp_b);
    @(posedge clk);
    #1;

    // Reset during ACCESS: response dropped, committed store survives
    btn = 4'b0000;
    m_btn = btn;
    tick(3);
    d = $urandom;
    bus.req_valid = 1'b1;
    bus.req_wren = 1'b1;
    bus.req_addr = 32'h2010;
    bus.req_funct3 = 3'b010;
    bus.st_data = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    model_access(1, 32'h2010, 3'b010, d, e, exp_a);
    rst_n = 1'b0;
    m_ledr = '0;
    m_ledg = '0;
    m_lcd = '0;
    m_evt = '0;
    m_hex = '{default: '0};
    #2;
    chk("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid.err", 32'(bus.rsp_err), 32'd0);
    chk("rst_mid.ld", bus.ld_data, 32'd0);
    chk_io("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(3);
    req("rst_mid.kept", 0, 32'h2010, 3'b010, 0);
    req("rst_mid.evt", 0, 32'h7814, 3'b010, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
